// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// stream/instruction widths and the checksum seed.
package prog_loader_pkg;

    localparam int HW_W = 16;
    localparam int INSTR_WIDTH = 32;
    localparam logic [HW_W-1:0] CKSUM_SEED = 16'h0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CHK   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

endpackage

// File: rtl/prog_loader_cksum.sv
// 16-bit XOR accumulator for the load stream; clear reloads the seed,
// enable folds the current halfword in.
module prog_loader_cksum
    import prog_loader_pkg::*;
(
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            clr,
    input  logic            en,
    input  logic [HW_W-1:0] din,
    output logic [HW_W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (sys_rst || clr) begin
            acc <= CKSUM_SEED;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory loader: count + halfword stream -> 32-bit writes, holds
// the CPU in reset until a complete load. Optional macro PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = INSTR_WIDTH
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               hw_valid,
    input  logic [HW_W-1:0]    hw_data,
    output logic               hw_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_rst_hold,
    output logic               done,
    output logic               err
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last_addr;
    logic              xfer;
    logic              len_ok;
    logic              ck_clr;
    logic              ck_en;
    logic              cksum_ok;

    assign xfer     = hw_valid && hw_ready;
    assign len_ok   = (hw_data != '0) && ({16'd0, hw_data} <= DEPTH);
    assign mem_addr = addr;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [HW_W-1:0] cksum;

    prog_loader_cksum u_cksum (
        .clk     (clk),
        .sys_rst (sys_rst),
        .clr     (ck_clr),
        .en      (ck_en),
        .din     (hw_data),
        .acc     (cksum)
    );

    assign cksum_ok = (hw_data == cksum);
`else
    logic unused_ck;
    assign unused_ck = ck_clr ^ ck_en;
    assign cksum_ok  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next         = state;
        hw_ready     = 1'b0;
        mem_we       = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        cpu_rst_hold = 1'b1;
        ck_clr       = 1'b0;
        ck_en        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next   = LEN;
                    ck_clr = 1'b1;
                end
            end
            LEN: begin
                hw_ready = 1'b1;
                if (hw_valid) begin
                    ck_en = 1'b1;
                    next  = len_ok ? HI : ERR;
                end
            end
            HI: begin
                hw_ready = 1'b1;
                if (hw_valid) begin
                    ck_en = 1'b1;
                    next  = LO;
                end
            end
            LO: begin
                hw_ready = 1'b1;
                if (hw_valid) begin
                    ck_en = 1'b1;
                    next  = WRITE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                if (addr == last_addr) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    next = CHK;
`else
                    next = DONE;
`endif
                end else begin
                    next = HI;
                end
            end
            CHK: begin
                hw_ready = 1'b1;
                if (hw_valid) begin
                    next = cksum_ok ? DONE : ERR;
                end
            end
            DONE: begin
                if (start) begin
                    next   = LEN;
                    ck_clr = 1'b1;
                end else begin
                    done         = 1'b1;
                    cpu_rst_hold = 1'b0;
                end
            end
            ERR: begin
                if (start) begin
                    next   = LEN;
                    ck_clr = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
            default: next = IDLE;
        endcase
    end

    // Datapath: address, last address (N-1) and the assembled instruction word.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            addr      <= '0;
            last_addr <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                LEN: begin
                    if (xfer) begin
                        addr      <= '0;
                        last_addr <= ADDR_W'(hw_data - 16'd1);
                    end
                end
                HI: begin
                    if (xfer) begin
                        mem_wdata[INSTR_W-1 -: HW_W] <= hw_data;
                    end
                end
                LO: begin
                    if (xfer) begin
                        mem_wdata[HW_W-1:0] <= hw_data;
                    end
                end
                WRITE: begin
                    // Stop at N-1 so a full-depth load never wraps back to 0.
                    if (addr != last_addr) begin
                        addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomized streams against a
// queue-based reference of expected writes and final status.
module tb_prog_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              sys_rst;
    logic              start;
    logic              hw_valid;
    logic [15:0]       hw_data;
    logic              hw_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_hold;
    logic              done;
    logic              err;

    int checks   = 0;
    int failures = 0;

    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] mem_model[DEPTH];
    logic [31:0] stim_w[$];

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .hw_valid     (hw_valid),
        .hw_data      (hw_data),
        .hw_ready     (hw_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_hold (cpu_rst_hold),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            mem_model[mem_addr] = mem_wdata;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_hw(input logic [15:0] d, input int max_stall);
        int ns;
        int guard;
        ns = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        for (int i = 0; i < ns; i++) begin
            hw_valid = 1'b0;
            hw_data  = 16'($urandom);
            @(negedge clk);
            if (i >= 1) begin
                checks++;
                if (hw_ready !== 1'b1 || mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold ready=%b we=%b required ready=1 we=0", hw_ready, mem_we);
                end
            end
            @(posedge clk); #1;
        end
        hw_valid = 1'b1;
        hw_data  = d;
        guard    = 0;
        @(negedge clk);
        while (hw_ready !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (hw_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout ready=%b required 1", hw_ready);
        end
        @(posedge clk); #1;
        hw_valid = 1'b0;
    endtask

    // Runs one session: stim_w holds the words for a legal count.
    task automatic run_load(input int n_cnt, input int max_stall, input bit bad_ck, input string tag);
        logic [15:0] cnt16;
        logic [15:0] ck;
        bit          ok;
        bit          valid_n;
        int          nw;
        cnt16   = 16'(n_cnt);
        valid_n = (n_cnt >= 1) && (n_cnt <= DEPTH);
        ok      = valid_n;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_hw(cnt16, max_stall);
        ck = cnt16;
        if (valid_n) begin
            for (int i = 0; i < n_cnt; i++) begin
                send_hw(stim_w[i][31:16], max_stall);
                send_hw(stim_w[i][15:0], max_stall);
                ck = ck ^ stim_w[i][31:16] ^ stim_w[i][15:0];
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            send_hw(bad_ck ? (ck ^ 16'h0001) : ck, max_stall);
            ok = !bad_ck;
`endif
        end
        if (!valid_n) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || cpu_rst_hold !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s bad_count_status err=%b hold=%b done=%b required 1 1 0", tag, err, cpu_rst_hold, done);
            end
        end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
            @(negedge clk);
            checks++;
            if (done !== ok || err !== !ok || cpu_rst_hold !== !ok) begin
                failures++;
                $display("FAIL %s ck_status done=%b err=%b hold=%b required %b %b %b", tag, done, err, cpu_rst_hold, ok, !ok, !ok);
            end
`else
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b1 || int'(mem_addr) != n_cnt - 1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s last_write_t1 we=%b addr=%0d done=%b required 1 %0d 0", tag, mem_we, mem_addr, done, n_cnt - 1);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || cpu_rst_hold !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL %s done_t2 done=%b hold=%b err=%b required 1 0 0", tag, done, cpu_rst_hold, err);
            end
`endif
        end
        repeat (3) @(negedge clk);
        nw = valid_n ? n_cnt : 0;
        checks++;
        if (wr_addr_q.size() != nw) begin
            failures++;
            $display("FAIL %s write_count got=%0d required=%0d", tag, wr_addr_q.size(), nw);
        end else begin
            for (int i = 0; i < nw; i++) begin
                checks++;
                if (wr_addr_q[i] != i || wr_data_q[i] !== stim_w[i]) begin
                    failures++;
                    $display("FAIL %s write_%0d got %0d:%h required %0d:%h", tag, i, wr_addr_q[i], wr_data_q[i], i, stim_w[i]);
                end
            end
        end
        checks++;
        if (done !== ok || err !== !ok || cpu_rst_hold !== !ok) begin
            failures++;
            $display("FAIL %s final_status done=%b err=%b hold=%b required %b %b %b", tag, done, err, cpu_rst_hold, ok, !ok, !ok);
        end
    endtask

    task automatic fill_random(input int n);
        stim_w.delete();
        for (int i = 0; i < n; i++) stim_w.push_back($urandom);
    endtask

    task automatic test_reset();
        sys_rst  = 1'b1;
        start    = 1'b1;
        hw_valid = 1'b1;
        hw_data  = 16'h0002;
        repeat (3) @(posedge clk);
        #1;
        start    = 1'b0;
        hw_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hw_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b we=%b done=%b err=%b required 0 0 0 0", hw_ready, mem_we, done, err);
        end
        checks++;
        if (cpu_rst_hold !== 1'b1 || mem_wdata !== 32'h0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_data hold=%b wdata=%h addr=%0d required 1 0 0", cpu_rst_hold, mem_wdata, mem_addr);
        end
        @(posedge clk); #1;
        sys_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (hw_ready !== 1'b0 || cpu_rst_hold !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle ready=%b hold=%b required 0 1", hw_ready, cpu_rst_hold);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        stim_w.delete();
        stim_w.push_back(32'h12345678);
        stim_w.push_back(32'hABCD0001);
        run_load(2, 0, 1'b0, "directed_n2");
    endtask

    task automatic test_bad_count();
        stim_w.delete();
        run_load(0, 0, 1'b0, "count_zero");
        run_load(DEPTH + 1, 1, 1'b0, "count_over");
    endtask

    task automatic test_full_stall();
        fill_random(DEPTH);
        run_load(DEPTH, 3, 1'b0, "full_depth_stall");
    endtask

    task automatic test_reset_mid();
        logic [15:0] lo3;
        fill_random(6);
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'hDEAD_BEEF;
        pulse_start();
        send_hw(16'd6, 0);
        for (int i = 0; i < 3; i++) begin
            send_hw(stim_w[i][31:16], 1);
            send_hw(stim_w[i][15:0], 1);
        end
        send_hw(stim_w[3][31:16], 0);
        lo3      = stim_w[3][15:0];
        sys_rst  = 1'b1;
        start    = 1'b1;
        hw_valid = 1'b1;
        hw_data  = lo3;
        @(posedge clk); #1;
        sys_rst  = 1'b0;
        start    = 1'b0;
        hw_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hw_ready !== 1'b0 || cpu_rst_hold !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle ready=%b hold=%b done=%b we=%b required 0 1 0 0", hw_ready, cpu_rst_hold, done, mem_we);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 3 || mem_model[3] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL midrst_writes count=%0d mem3=%h required 3 deadbeef", wr_addr_q.size(), mem_model[3]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_model[i] !== stim_w[i]) begin
                failures++;
                $display("FAIL midrst_word_%0d got=%h required=%h", i, mem_model[i], stim_w[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 6; k++) begin
            n = ($urandom_range(4, 0) == 0) ? int'($urandom_range(40, 17)) : int'($urandom_range(DEPTH, 1));
            if (k == 2) n = 0;
            fill_random((n >= 1 && n <= DEPTH) ? n : 0);
            run_load(n, 2, 1'b0, "back_to_back");
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        stim_w.delete();
        stim_w.push_back(32'h00FF0F00);
        run_load(1, 0, 1'b0, "ck_good");
        run_load(1, 0, 1'b1, "ck_bad");
        run_load(1, 1, 1'b0, "ck_recover");
    endtask
`endif

    initial begin
        sys_rst  = 1'b1;
        start    = 1'b0;
        hw_valid = 1'b0;
        hw_data  = 16'h0;
        test_reset();
        test_directed();
        test_bad_count();
        test_full_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 4: instruction memory address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter INSTR_W, default 32: instruction word width, fixed at two 16-bit halfwords.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 hw_valid  input  1  halfword present on hw_data.
REQ-007 hw_data  input  16  halfword stream: count, then instruction halfwords (upper first).
REQ-008 hw_ready  output  1  loader accepts a halfword this cycle.
REQ-009 mem_we  output  1  instruction memory write strobe.
REQ-010 mem_addr  output  ADDR_W  instruction memory write address.
REQ-011 mem_wdata  output  32  instruction word written.
REQ-012 cpu_rst_hold  output  1  holds the processor in reset while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load aborted (bad count or checksum).

Function
REQ-015 The loader SHALL be the writer side of the processor's instruction memory; it releases the processor only after a complete, valid load.
REQ-016 FSM states SHALL be IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR.
REQ-017 A transfer SHALL occur only on a cycle where hw_valid and hw_ready are both high. hw_ready SHALL be 1 only in LEN, HI, LO, CHK.
REQ-018 IDLE->LEN on start. start SHALL be ignored in LEN, HI, LO, WRITE and CHK.
REQ-019 In LEN the transfer SHALL latch count N = hw_data. 1 <= N <= DEPTH SHALL go to HI with addr=0. Any other N SHALL go to ERR with no writes.
REQ-020 HI SHALL latch hw_data into mem_wdata[31:16] and go to LO. LO SHALL latch hw_data into mem_wdata[15:0] and go to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=current addr and the assembled word stable. If this was the last instruction (addr==N-1), the next state SHALL be CHK when checksum is compiled in, else DONE. Otherwise addr SHALL increment and the next state SHALL be HI.
REQ-022 Latency: the LO transfer at cycle t SHALL give mem_we at t+1. For the last word without checksum, done=1 and cpu_rst_hold=0 SHALL follow at t+2.
REQ-023 addr SHALL never exceed N-1. N=DEPTH SHALL write address DEPTH-1 last, with no wrap to 0.
REQ-024 DONE SHALL drive done=1 and cpu_rst_hold=0. ERR SHALL drive err=1 and cpu_rst_hold=1. Both states SHALL go to LEN on start, clearing done/err and setting cpu_rst_hold=1 in that cycle.
REQ-025 cpu_rst_hold SHALL be 1 in every state except DONE.
REQ-026 hw_valid low in any accepting state SHALL stall with no state change. There is no timeout.

Reset
REQ-027 sys_rst SHALL force IDLE, addr=0, mem_wdata=0, mem_we=0, hw_ready=0, done=0, err=0, cpu_rst_hold=1, and the checksum accumulator to 0.
REQ-028 sys_rst mid-session SHALL abandon the session in the same edge. Words already written stay in memory, and no partial word is written.
REQ-029 sys_rst SHALL take priority over start and over any handshake in the same cycle.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN: when defined, the loader SHALL keep a 16-bit XOR of the count and all instruction halfwords. CHK SHALL accept one trailing halfword and go to DONE if it equals the XOR, else to ERR.
REQ-031 When PROG_LOADER_CHECKSUM_EN is undefined, the CHK state and accumulator SHALL be absent, and the stream SHALL be the count plus 2N halfwords only.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the halfword width (16), the instruction width (32) and the checksum seed (0).
REQ-033 One sub-module, prog_loader_cksum (XOR accumulator with clear/enable), is natural. It SHALL be instantiated only under PROG_LOADER_CHECKSUM_EN.

Verification
REQ-034 Reset, start, stream N=2: 0x0002, 0x1234, 0x5678, 0xABCD, 0x0001 -> writes 0x12345678@0 and 0xABCD0001@1; done=1 and cpu_rst_hold=0 two cycles after the last transfer.
REQ-035 Count 0x0000, then separately 0x0011 (ADDR_W=4) -> err=1, cpu_rst_hold=1, no mem_we pulses.
REQ-036 N=16 with hw_valid toggled randomly -> 16 writes at addresses 0..15 in order, no write to 0 after 15, stalls cause no state change.
REQ-037 Assert sys_rst between HI and LO of word 3 -> IDLE next cycle, words 0-2 intact, no write at address 3, cpu_rst_hold=1.
REQ-038 With PROG_LOADER_CHECKSUM_EN, N=1, stream 0x0001, 0x00FF, 0x0F00 plus checksum 0x0FFE -> done=1. Checksum 0x0FFF instead -> err=1. A subsequent start then a good stream -> done=1.
